// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared types and default widths for the local-injection arbiter.
//   NOC_DATA_W  : default flit width
//   NOC_NUM_REQ : default requester count
//   arb_state_e : packet-lock FSM states
//   flit_mark_t : header/tail markers carried alongside a flit
package noc_local_inject_arbiter_pkg;

    localparam int unsigned NOC_DATA_W  = 32;
    localparam int unsigned NOC_NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic is_header;
        logic is_tail;
    } flit_mark_t;

endpackage

// File: rtl/noc_local_inject_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
//   i_req   : request vector
//   i_ptr   : highest-priority index
//   o_grant : one-hot grant
//   o_idx   : grant index
//   o_any   : at least one request present
module noc_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Modular add that also works for non-power-of-two NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin : p_pick
        logic [IDX_W-1:0] k;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = wrap_add(i_ptr, i);
            if (!o_any && i_req[k]) begin
                o_any      = 1'b1;
                o_idx      = k;
                o_grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Shares one router local-injection port among NUM_REQ sources, granting whole packets
// round-robin and holding the grant from header to tail. One registered output stage.
//   noc_clk/noc_rst_n            : clock, async active-low reset
//   req_valid/ready/flit/markers : per-requester flit stream
//   out_valid/ready/flit/markers : registered stream to router local port
//   grant_idx                    : current packet owner
//   locked                       : packet in progress
//   err_hdr                      : sticky, owner sent a header before its tail
module noc_local_inject_arbiter
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NOC_NUM_REQ,
    parameter  int unsigned DATA_W  = NOC_DATA_W,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_flit,
    input  logic [NUM_REQ-1:0]        req_is_header,
    input  logic [NUM_REQ-1:0]        req_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      locked,
    output logic                      err_hdr
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic                r_err_hdr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_flit;
    flit_mark_t          r_out_mark;

    logic                w_stage_free;
    logic [NUM_REQ-1:0]  w_cand;
    logic [NUM_REQ-1:0]  w_rr_grant;
    logic [IDX_W-1:0]    w_rr_idx;
    logic                w_rr_any;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_accept;
    logic [IDX_W-1:0]    w_sel;
    logic                w_err_set;
    logic [DATA_W-1:0]   w_flit_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_flit_arr[g] = req_flit[g*DATA_W +: DATA_W];
    end

    // Stage can take a flit if empty or draining this cycle.
    assign w_stage_free = !r_out_valid || out_ready;
    assign w_cand       = req_valid & req_is_header;

    noc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req   (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // Packet-lock FSM: next state, ready decode, accept strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        w_sel       = r_grant_idx;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_any) begin
                    w_sel    = w_rr_idx;
                    w_ready  = w_stage_free ? w_rr_grant : '0;
                    w_accept = w_stage_free;
                    if (w_accept && !req_is_tail[w_rr_idx]) w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_ready[r_grant_idx] = w_stage_free;
                w_accept             = w_stage_free && req_valid[r_grant_idx];
                if (w_accept) begin
                    if (req_is_tail[r_grant_idx]) w_state_nxt = ST_IDLE;
                    else if (req_is_header[r_grant_idx]) w_err_set = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Grant owner, round-robin pointer and sticky error.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_err_hdr   <= 1'b0;
        end else begin
            if (w_accept && (r_state == ST_IDLE)) begin
                r_grant_idx <= w_rr_idx;
                r_rr_ptr    <= (w_rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_rr_idx + IDX_W'(1);
            end
            if (w_err_set) r_err_hdr <= 1'b1;
        end
    end

    // Output register stage; holds while the router stalls.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_mark  <= '0;
        end else if (w_accept) begin
            r_out_valid          <= 1'b1;
            r_out_flit           <= w_flit_arr[w_sel];
            r_out_mark.is_header <= req_is_header[w_sel];
            r_out_mark.is_tail   <= req_is_tail[w_sel];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign req_ready     = w_ready;
    assign out_valid     = r_out_valid;
    assign out_flit      = r_out_flit;
    assign out_is_header = r_out_mark.is_header;
    assign out_is_tail   = r_out_mark.is_tail;
    assign grant_idx     = r_grant_idx;
    assign locked        = (r_state == ST_LOCKED);
    assign err_hdr       = r_err_hdr;

endmodule
